// File: rtl/fifo_frame_reader.sv
// Read-side frame parser for the dual-clock FIFO.
// Prefetches words into a small buffer and strips length headers.
module fifo_frame_reader #(
    parameter int BUF_DEPTH = 4,
    parameter int MAX_LEN   = 1024
) (
    input  logic        rdclk,
    input  logic        aclr,
    input  logic [15:0] fifo_q,
    input  logic        fifo_rdempty,
    output logic        fifo_rdreq,
    output logic [15:0] out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_sop,
    output logic        out_eop,
    output logic        hdr_err,
    output logic [15:0] frame_count
);

    localparam int AW = $clog2(BUF_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic {HDR, PAY} state_t;

    state_t        state;
    state_t        state_nx;
    logic [15:0]   mem [BUF_DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [CW-1:0] count;
    logic          rd_pend;
    logic [15:0]   remaining;
    logic [15:0]   hlen;
    logic [15:0]   head;
    logic          buf_ne;
    logic          hdr_bad;
    logic          hdr_pop;
    logic          push;
    logic          pop;
    logic          beat;
    logic          eop_beat;

    assign head    = mem[rptr];
    assign buf_ne  = (count != '0);
    assign hdr_bad = (head == 16'd0) || (head > 16'(MAX_LEN));
    assign push    = rd_pend;

    // Counts the word already in flight so the buffer can never overflow.
    assign fifo_rdreq = !aclr && !fifo_rdempty &&
                        ((count + CW'(rd_pend)) < CW'(BUF_DEPTH));

    always_ff @(posedge rdclk or posedge aclr) begin
        if (aclr) state <= HDR;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            HDR: if (buf_ne && !hdr_bad) state_nx = PAY;
            PAY: if (eop_beat)           state_nx = HDR;
        endcase
    end

    always_comb begin
        out_valid = 1'b0;
        out_data  = '0;
        out_sop   = 1'b0;
        out_eop   = 1'b0;
        hdr_pop   = 1'b0;
        unique case (state)
            HDR: hdr_pop = buf_ne;
            PAY: begin
                out_valid = buf_ne;
                out_data  = head;
                out_sop   = buf_ne && (remaining == hlen);
                out_eop   = buf_ne && (remaining == 16'd1);
            end
        endcase
    end

    assign beat     = out_valid && out_ready;
    assign eop_beat = beat && out_eop;
    assign pop      = hdr_pop || beat;

    always_ff @(posedge rdclk) begin
        if (push) mem[wptr] <= fifo_q;
    end

    always_ff @(posedge rdclk or posedge aclr) begin
        if (aclr) begin
            wptr        <= '0;
            rptr        <= '0;
            count       <= '0;
            rd_pend     <= 1'b0;
            remaining   <= '0;
            hlen        <= '0;
            hdr_err     <= 1'b0;
            frame_count <= '0;
        end else begin
            rd_pend <= fifo_rdreq;
            hdr_err <= hdr_pop && hdr_bad;
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
            if (hdr_pop && !hdr_bad) begin
                remaining <= head;
                hlen      <= head;
            end else if (beat) begin
                remaining <= remaining - 1'b1;
            end
            if (eop_beat) frame_count <= frame_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_fifo_frame_reader.sv
// Directed bench for fifo_frame_reader.
// Behavioural FIFO model feeds words; a monitor records payload beats.
module tb_fifo_frame_reader;

    logic        rdclk = 1'b0;
    logic        aclr = 1'b1;
    logic [15:0] fifo_q = '0;
    logic        fifo_rdempty = 1'b1;
    logic        fifo_rdreq;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        out_sop;
    logic        out_eop;
    logic        hdr_err;
    logic [15:0] frame_count;

    always #5 rdclk = ~rdclk;

    fifo_frame_reader dut (
        .rdclk       (rdclk),
        .aclr        (aclr),
        .fifo_q      (fifo_q),
        .fifo_rdempty(fifo_rdempty),
        .fifo_rdreq  (fifo_rdreq),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_sop     (out_sop),
        .out_eop     (out_eop),
        .hdr_err     (hdr_err),
        .frame_count (frame_count)
    );

    typedef struct {
        logic [15:0] w;
        logic        fwd;
        logic        sop;
        logic        eop;
    } vec_t;

    typedef struct {
        logic [15:0] d;
        logic        sop;
        logic        eop;
    } beat_t;

    vec_t        tv[$];
    beat_t       rx[$];
    int          rx_cyc[$];
    logic [15:0] fq[$];

    int    nvec = 0;
    int    nerr = 0;
    int    cyc = 0;
    int    err_cnt = 0;
    int    full_seen = 0;
    int    first_req = -1;
    int    first_val = -1;
    logic  stall_q = 1'b0;
    beat_t stall_b;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h want 0x%0h (t=%0t)",
                     name, act, exp, $time);
        end
    endtask

    function automatic void add(logic [15:0] w, logic f, logic s, logic e);
        tv.push_back('{w, f, s, e});
    endfunction

    // Non-show-ahead FIFO: q updates on the edge that sees rdreq.
    always @(posedge rdclk) begin
        cyc <= cyc + 1;
        if (fifo_rdreq && fq.size() != 0) fifo_q <= fq.pop_front();
        fifo_rdempty <= (fq.size() == 0);
    end

    always @(negedge rdclk) begin
        if (fifo_rdreq) check("rdreq_vs_empty", 32'(fifo_rdempty), 32'd0);
        if (!aclr && !fifo_rdempty && !fifo_rdreq) full_seen++;
        if (hdr_err) err_cnt++;
        if (fifo_rdreq && first_req < 0) first_req = cyc;
        if (out_valid && first_val < 0) first_val = cyc;
        if (stall_q) begin
            check("stall_valid", 32'(out_valid), 32'd1);
            check("stall_hold", {14'd0, out_sop, out_eop, out_data},
                  {14'd0, stall_b.sop, stall_b.eop, stall_b.d});
        end
        stall_q = out_valid && !out_ready && !aclr;
        stall_b = '{out_data, out_sop, out_eop};
        if (out_valid && out_ready) begin
            rx.push_back('{out_data, out_sop, out_eop});
            rx_cyc.push_back(cyc);
        end
    end

    task automatic run_seg(input int lo, input int hi, input int mode,
                           input int exp_err);
        int   base;
        int   nexp;
        int   j;
        logic done;
        base    = rx.size();
        nexp    = 0;
        done    = 1'b0;
        err_cnt = 0;
        for (int i = lo; i < hi; i++) begin
            fq.push_back(tv[i].w);
            nexp += int'(tv[i].fwd);
        end
        for (int k = 0; k < 300 && !done; k++) begin
            @(posedge rdclk);
            #1;
            out_ready = (mode == 0) || (k % 4 == 0) || (k % 4 == 3);
            if (rx.size() - base >= nexp && fq.size() == 0) done = 1'b1;
        end
        check("seg_done", 32'(done), 32'd1);
        out_ready = 1'b1;
        repeat (4) @(posedge rdclk);
        #1;
        check("beat_count", 32'(rx.size() - base), 32'(nexp));
        j = base;
        for (int i = lo; i < hi; i++) begin
            if (tv[i].fwd) begin
                if (j < rx.size()) begin
                    check("beat_data", 32'(rx[j].d), 32'(tv[i].w));
                    check("beat_sop", 32'(rx[j].sop), 32'(tv[i].sop));
                    check("beat_eop", 32'(rx[j].eop), 32'(tv[i].eop));
                end
                j++;
            end
        end
        check("hdr_err_cycles", 32'(err_cnt), 32'(exp_err));
    endtask

    initial begin
        int   b;
        logic got2;
        add(16'h0003, 0, 0, 0);
        add(16'hA001, 1, 1, 0);
        add(16'hA002, 1, 0, 0);
        add(16'hA003, 1, 0, 1);
        add(16'h0000, 0, 0, 0);
        add(16'h0401, 0, 0, 0);
        add(16'h0001, 0, 0, 0);
        add(16'hBEEF, 1, 1, 1);
        add(16'h0008, 0, 0, 0);
        for (int i = 0; i < 8; i++)
            add(16'hC000 + 16'(i), 1, logic'(i == 0), logic'(i == 7));
        add(16'h0002, 0, 0, 0);
        add(16'hD001, 1, 1, 0);
        add(16'hD002, 1, 0, 1);
        add(16'h0002, 0, 0, 0);
        add(16'hD003, 1, 1, 0);
        add(16'hD004, 1, 0, 1);
        add(16'h0001, 0, 0, 0);
        add(16'h1234, 1, 1, 1);

        repeat (3) @(posedge rdclk);
        #1;
        check("rst_rdreq", 32'(fifo_rdreq), 32'd0);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_sop", 32'(out_sop), 32'd0);
        check("rst_eop", 32'(out_eop), 32'd0);
        check("rst_hdr_err", 32'(hdr_err), 32'd0);
        check("rst_frames", 32'(frame_count), 32'd0);
        aclr = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge rdclk);
            #1;
            check("idle_rdreq", 32'(fifo_rdreq), 32'd0);
            check("idle_valid", 32'(out_valid), 32'd0);
        end

        run_seg(0, 4, 0, 0);
        check("first_latency", 32'(first_val - first_req), 32'd3);
        check("frames_1", 32'(frame_count), 32'd1);

        run_seg(4, 8, 0, 2);
        check("frames_2", 32'(frame_count), 32'd2);

        full_seen = 0;
        run_seg(8, 17, 1, 0);
        check("rdreq_drops_full", 32'(full_seen > 0), 32'd1);
        check("frames_3", 32'(frame_count), 32'd3);

        b = rx.size();
        run_seg(17, 23, 0, 0);
        if (rx.size() >= b + 3)
            check("b2b_bubble", 32'(rx_cyc[b+2] - rx_cyc[b+1]), 32'd2);
        check("frames_5", 32'(frame_count), 32'd5);

        b = rx.size();
        got2 = 1'b0;
        fq.push_back(16'h0005);
        for (int i = 1; i <= 5; i++) fq.push_back(16'hE000 + 16'(i));
        for (int k = 0; k < 100 && !got2; k++) begin
            @(posedge rdclk);
            #1;
            if (rx.size() - b >= 2) got2 = 1'b1;
        end
        check("two_beats_seen", 32'(got2), 32'd1);
        aclr = 1'b1;
        #1;
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_sop", 32'(out_sop), 32'd0);
        check("mid_rst_eop", 32'(out_eop), 32'd0);
        check("mid_rst_rdreq", 32'(fifo_rdreq), 32'd0);
        check("mid_rst_frames", 32'(frame_count), 32'd0);
        fq.delete();
        repeat (2) @(posedge rdclk);
        #1;
        aclr = 1'b0;
        check("abort_beats", 32'(rx.size() - b), 32'd2);
        if (rx.size() >= b + 2) begin
            check("abort_d0", 32'(rx[b].d), 32'hE001);
            check("abort_sop0", 32'(rx[b].sop), 32'd1);
            check("abort_d1", 32'(rx[b+1].d), 32'hE002);
            check("abort_eop1", 32'(rx[b+1].eop), 32'd0);
        end
        run_seg(23, 25, 0, 0);
        check("frames_after_rst", 32'(frame_count), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/fifo_frame_reader.md
Name: fifo_frame_reader

Overview:
- Read-side consumer of the 16-bit dual-clock FIFO. Runs entirely in the FIFO read clock domain.
- Drains words through the FIFO's rdreq/q read port (non-show-ahead: q is valid one cycle after rdreq) and parses them into length-prefixed frames.
- Presents payload on a valid/ready stream with start/end-of-frame markers.
- Header words are consumed and never forwarded.

Parameters:
- BUF_DEPTH, 4: local prefetch buffer entries (power of 2, ≥2); covers the 1-cycle FIFO read latency.
- MAX_LEN, 1024: largest legal payload length in words.

Ports:
- rdclk  in  1  clock (FIFO read clock).
- aclr  in  1  asynchronous active-high reset.
- fifo_q  in  16  FIFO read data, valid the cycle after fifo_rdreq.
- fifo_rdempty  in  1  FIFO empty flag, read domain.
- fifo_rdreq  out  1  FIFO read request.
- out_data  out  16  payload word.
- out_valid  out  1  out_data valid.
- out_ready  in  1  downstream accepts; transfer = out_valid & out_ready.
- out_sop  out  1  first payload word of frame; qualified by out_valid.
- out_eop  out  1  last payload word of frame; qualified by out_valid.
- hdr_err  out  1  one-cycle pulse: illegal header dropped.
- frame_count  out  16  completed frames (eop transfers), wraps 0xFFFF→0.

Behaviour:
- Reset (aclr=1, asynchronous): fifo_rdreq=0, out_valid=0, out_sop=0, out_eop=0, hdr_err=0, frame_count=0. Buffer emptied, pending-read flag cleared, state=HDR, remaining=0.
- Reset asserted mid-frame: the partial frame is abandoned. The in-flight FIFO word is discarded and does not re-appear after release.
- Prefetch:
  - rd_pend is the registered copy of fifo_rdreq.
  - fifo_rdreq = !fifo_rdempty && (buf_count + rd_pend + push_pending_pop_adjust) < BUF_DEPTH. Implement this conservatively as buf_count + rd_pend < BUF_DEPTH, evaluated from registered state only.
  - When rd_pend=1, fifo_q is written into the buffer tail that cycle.
  - The buffer never overflows. fifo_rdreq is never asserted while fifo_rdempty=1.
- Buffer:
  - FIFO ordering.
  - Simultaneous push and pop in the same cycle is allowed; count is unchanged.
  - Pointers wrap modulo BUF_DEPTH.
- State HDR:
  - If the buffer is non-empty, pop the head as header N, with out_valid=0.
  - 1 ≤ N ≤ MAX_LEN: remaining←N, state←PAY.
  - N=0 or N>MAX_LEN: header dropped, hdr_err=1 the next cycle, stay in HDR.
- State PAY:
  - out_valid = buffer non-empty; out_data = buffer head.
  - out_sop = (remaining == latched N).
  - out_eop = (remaining == 1).
  - On transfer: pop, remaining←remaining−1.
  - If eop is transferred: state←HDR, frame_count+1.
  - out_data, out_sop and out_eop are held stable while out_valid=1 and out_ready=0.
- Single-word frame (N=1): out_sop and out_eop are both 1 on the same beat.
- Latency from an idle, empty design with a non-empty FIFO:
  - cycle 0: rdreq for the header.
  - cycle 1: header captured.
  - cycle 2: header popped (HDR).
  - cycle 3: first payload beat valid, provided the payload word was prefetched.
- Throughput: one payload word per cycle sustained while the FIFO is non-empty and out_ready=1.
- Back-to-back frames: the header of the next frame costs one bubble cycle after eop.
- Back-pressure: with out_ready=0, the buffer fills to BUF_DEPTH and fifo_rdreq deasserts. No word is lost or duplicated.

Test Plan:
- Reset-release with an empty FIFO: all outputs 0, fifo_rdreq stays 0.
- FIFO holds 0x0003, 0xA001, 0xA002, 0xA003; out_ready=1:
  - three beats A001/A002/A003;
  - sop on A001 only, eop on A003 only;
  - frame_count=1; header never on out_data.
- Headers 0x0000, then 0x0401 (1025 > MAX_LEN), then 0x0001, 0xBEEF:
  - two hdr_err pulses;
  - single beat 0xBEEF with sop=eop=1;
  - frame_count=1.
- Frame N=8 with out_ready toggling 1,0,0,1 repeatedly:
  - fifo_rdreq drops when the buffer is full;
  - 8 beats in order with no duplicates;
  - out_data stable during stalls.
- Two frames back-to-back (N=2 then N=2): exactly one bubble between eop and the next sop; frame_count=2.
- aclr pulsed after 2 of 5 payload beats:
  - outputs reset immediately;
  - after release, the next FIFO word (a new header 0x0001, 0x1234) yields a single beat 0x1234.
